// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its requester arbiter: width, op codes, lock states.
package alu_pkg;

    localparam int unsigned W = 8;

    localparam logic [2:0] ALU_PASS_A  = 3'b000;
    localparam logic [2:0] ALU_ADD_OVF = 3'b001;
    localparam logic [2:0] ALU_AND     = 3'b010;
    localparam logic [2:0] ALU_XOR     = 3'b011;
    localparam logic [2:0] ALU_PASS_B  = 3'b100;
    localparam logic [2:0] ALU_ADD     = 3'b101;

    typedef enum logic {
        StOpen,
        StLocked
    } arb_state_e;

endpackage

// File: rtl/rr_grant.sv
// Round-robin priority picker: first requester at or after ptr_i (with wrap) that is
// both requesting and unmasked gets a one-hot grant. Purely combinational.
module rr_grant #(
    parameter int unsigned N    = 2,
    parameter int unsigned PtrW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [N-1:0]    mask_i,
    input  logic [PtrW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o
);

    always_comb begin
        int unsigned idx;
        logic        found;
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req_i[idx] && mask_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between NUM_REQ requesters with round-robin arbitration and an
// ownership lock so multi-op sequences can use the shared OVF flag atomically.
module alu_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned W       = alu_pkg::W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ-1:0]   req_lock,
    input  logic [3*NUM_REQ-1:0] req_op,
    input  logic [W*NUM_REQ-1:0] req_a,
    input  logic [W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]   resp_valid,
    output logic [W-1:0]         resp_data,
    output logic                 resp_ovf,
    output logic                 resp_nz,
    output logic [2:0]           alu_op,
    output logic [W-1:0]         alu_a,
    output logic [W-1:0]         alu_b,
    input  logic [W-1:0]         alu_out,
    input  logic                 alu_ovf,
    input  logic                 alu_nz
);

    import alu_pkg::*;

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    arb_state_e          state_q;
    logic [IdxW-1:0]     owner_q;
    logic [IdxW-1:0]     rr_q;
    logic [NUM_REQ-1:0]  mask;
    logic [NUM_REQ-1:0]  gnt;
    logic                xfer;
    logic [IdxW-1:0]     gnt_idx;
    logic [IdxW-1:0]     rr_next;
    logic [2:0]          op_sel;
    logic [W-1:0]        a_sel;
    logic [W-1:0]        b_sel;
    logic                lock_sel;
    logic [2:0]          alu_op_q;
    logic [W-1:0]        alu_a_q;
    logic [W-1:0]        alu_b_q;
    logic                s1_valid_q;
    logic [IdxW-1:0]     s1_idx_q;
    logic                s2_valid_q;
    logic [IdxW-1:0]     s2_idx_q;

    // While locked only the owner is eligible; the picker then degenerates to a single bit.
    always_comb begin
        mask = '0;
        if (state_q == StOpen) begin
            mask = '1;
        end else begin
            mask[owner_q] = 1'b1;
        end
    end

    rr_grant #(
        .N    (NUM_REQ),
        .PtrW (IdxW)
    ) u_rr_grant (
        .req_i  (req_valid),
        .mask_i (mask),
        .ptr_i  (rr_q),
        .gnt_o  (gnt)
    );

    assign req_ready = gnt;

    always_comb begin
        int unsigned sel;
        xfer    = |gnt;
        gnt_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_idx = IdxW'(i);
            end
        end
        sel      = 32'(gnt_idx);
        op_sel   = req_op[3*sel +: 3];
        a_sel    = req_a[W*sel +: W];
        b_sel    = req_b[W*sel +: W];
        lock_sel = req_lock[sel];
        rr_next  = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StOpen;
            owner_q  <= '0;
            rr_q     <= '0;
            alu_op_q <= ALU_PASS_A;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
        end else if (xfer) begin
            alu_op_q <= op_sel;
            alu_a_q  <= a_sel;
            alu_b_q  <= b_sel;
            // Pointer is frozen while locked so the lock doesn't skew the rotation.
            if (state_q == StOpen) begin
                rr_q <= rr_next;
            end
            if (lock_sel) begin
                state_q <= StLocked;
                owner_q <= gnt_idx;
            end else begin
                state_q <= StOpen;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_idx_q   <= '0;
        end else begin
            s1_valid_q <= xfer;
            s1_idx_q   <= gnt_idx;
            s2_valid_q <= s1_valid_q;
            s2_idx_q   <= s1_idx_q;
        end
    end

    always_comb begin
        resp_valid = '0;
        if (s2_valid_q) begin
            resp_valid[s2_idx_q] = 1'b1;
        end
    end

    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign resp_data = alu_out;
    assign resp_ovf  = alu_ovf;
    assign resp_nz   = alu_nz;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter with a behavioural ALU attached and a response scoreboard.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_lock;
    logic [5:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [1:0]  resp_valid;
    logic [7:0]  resp_data;
    logic        resp_ovf;
    logic        resp_nz;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_out;
    logic        alu_ovf;
    logic        alu_nz;

    logic [2:0]  op0, op1;
    logic [7:0]  a0, a1, b0, b1;

    assign req_op = {op1, op0};
    assign req_a  = {a1, a0};
    assign req_b  = {b1, b0};

    alu_arbiter #(.NUM_REQ(2), .W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_lock   (req_lock),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_ovf   (resp_ovf),
        .resp_nz    (resp_nz),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out    (alu_out),
        .alu_ovf    (alu_ovf),
        .alu_nz     (alu_nz)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] alu_calc(input logic [2:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
        case (op)
            3'b000:         return a;
            3'b001, 3'b101: return a + b;
            3'b010:         return a & b;
            3'b011:         return a ^ b;
            3'b100:         return b;
            default:        return 8'h00;
        endcase
    endfunction

    function automatic logic alu_carry(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8];
    endfunction

    // Behavioural ALU: registered result, sticky OVF updated only by op 001, no reset.
    always @(posedge clk) begin
        alu_out <= alu_calc(alu_op, alu_a, alu_b);
        alu_nz  <= |alu_a;
        if (alu_op == 3'b001) alu_ovf <= alu_carry(alu_a, alu_b);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int         idx;
        logic [7:0] data;
        logic       ovf;
        logic       nz;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    logic exp_ovf = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        exp_t x;
        if (rst_n) begin
            if (sb.size() > 0 && resp_valid == 2'b00 && cyc >= sb[0].cyc + 2) begin
                x = sb.pop_front();
                check_eq("resp_missing", 32'(resp_valid), 32'(1) << x.idx);
            end
            if (resp_valid != 2'b00) begin
                if (sb.size() == 0) begin
                    check_eq("resp_unexpected", 32'(resp_valid), 32'h0);
                end else begin
                    x = sb.pop_front();
                    check_eq("resp_valid", 32'(resp_valid), 32'(1) << x.idx);
                    check_eq("resp_data", 32'(resp_data), 32'(x.data));
                    check_eq("resp_ovf", 32'(resp_ovf), 32'(x.ovf));
                    check_eq("resp_nz", 32'(resp_nz), 32'(x.nz));
                    check_eq("resp_latency", 32'(cyc - x.cyc), 32'd2);
                end
            end
            if (req_ready != 2'b00) begin
                check_eq("ready_onehot", 32'($onehot(req_ready)), 32'd1);
                check_eq("ready_subset", 32'(req_ready & ~req_valid), 32'h0);
            end
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.idx  = i;
                    e.data = alu_calc(req_op[3*i +: 3], req_a[8*i +: 8], req_b[8*i +: 8]);
                    if (req_op[3*i +: 3] == 3'b001) begin
                        exp_ovf = alu_carry(req_a[8*i +: 8], req_b[8*i +: 8]);
                    end
                    e.ovf = exp_ovf;
                    e.nz  = |req_a[8*i +: 8];
                    e.cyc = cyc;
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b00; req_lock = 2'b00;
        op0 = 3'b000; a0 = 8'h00; b0 = 8'h00;
        op1 = 3'b000; a1 = 8'h00; b1 = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'h0);
        check_eq("rst_alu_op", 32'(alu_op), 32'h0);
        check_eq("rst_alu_a", 32'(alu_a), 32'h0);
        check_eq("rst_alu_b", 32'(alu_b), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single add-with-overflow from requester 0.
        req_valid = 2'b01; op0 = 3'b001; a0 = 8'hF0; b0 = 8'h20;
        @(negedge clk); check_eq("t1_ready", 32'(req_ready), 32'h1);
        tick(); req_valid = 2'b00;
        @(negedge clk); check_eq("t1_early", 32'(resp_valid), 32'h0);
        tick();
        @(negedge clk);
        check_eq("t1_resp_valid", 32'(resp_valid), 32'h1);
        check_eq("t1_data", 32'(resp_data), 32'h10);
        check_eq("t1_ovf", 32'(resp_ovf), 32'h1);
        check_eq("t1_nz", 32'(resp_nz), 32'h1);

        // Requester 1 op moves the pointer back to 0 and clears the carry.
        tick();
        req_valid = 2'b10; op1 = 3'b001; a1 = 8'h01; b1 = 8'h02;
        @(negedge clk); check_eq("t2_prep", 32'(req_ready), 32'h2);

        // Contention: strict alternation.
        tick();
        req_valid = 2'b11;
        op0 = 3'b101; a0 = 8'h01; b0 = 8'h02;
        op1 = 3'b010; a1 = 8'hFF; b1 = 8'h0F;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("t2_grant", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            tick();
        end
        req_valid = 2'b00;
        @(negedge clk);
        check_eq("t2_resp0", 32'(resp_valid), 32'h1);
        check_eq("t2_data0", 32'(resp_data), 32'h03);
        tick();
        @(negedge clk);
        check_eq("t2_resp1", 32'(resp_valid), 32'h2);
        check_eq("t2_data1", 32'(resp_data), 32'h0F);
        tick();

        // Locked add then carry test; requester 1 waits throughout.
        req_valid = 2'b11; req_lock = 2'b01;
        op0 = 3'b001; a0 = 8'hFF; b0 = 8'h01;
        op1 = 3'b011; a1 = 8'h33; b1 = 8'h0F;
        @(negedge clk); check_eq("t3_first", 32'(req_ready), 32'h1);
        tick();
        op0 = 3'b000; a0 = 8'h00; b0 = 8'h00; req_lock = 2'b00;
        @(negedge clk); check_eq("t3_owner", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b10;
        @(negedge clk);
        check_eq("t3_release", 32'(req_ready), 32'h2);
        check_eq("t3_r0_data", 32'(resp_data), 32'h00);
        check_eq("t3_r0_ovf", 32'(resp_ovf), 32'h1);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        check_eq("t3_r1_valid", 32'(resp_valid), 32'h1);
        check_eq("t3_r1_ovf", 32'(resp_ovf), 32'h1);
        check_eq("t3_r1_nz", 32'(resp_nz), 32'h0);
        tick();

        // Owner idles while locked.
        req_valid = 2'b11; req_lock = 2'b01;
        op0 = 3'b101; a0 = 8'h10; b0 = 8'h20;
        op1 = 3'b100; a1 = 8'h00; b1 = 8'h77;
        @(negedge clk); check_eq("t4_lock", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b10;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); check_eq("t4_held", 32'(req_ready), 32'h0);
            tick();
        end
        req_valid = 2'b11; op0 = 3'b000; a0 = 8'h80; req_lock = 2'b00;
        @(negedge clk); check_eq("t4_unlock", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b10;
        @(negedge clk); check_eq("t4_next", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b00;
        tick(); tick();

        // Reset while locked with an op in flight.
        req_valid = 2'b11; req_lock = 2'b01;
        op0 = 3'b010; a0 = 8'hAA; b0 = 8'h0F;
        op1 = 3'b100; a1 = 8'h00; b1 = 8'h11;
        @(negedge clk); check_eq("t5_lock", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b10;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check_eq("t5_resp_valid", 32'(resp_valid), 32'h0);
        check_eq("t5_alu_op", 32'(alu_op), 32'h0);
        check_eq("t5_state_open", 32'(req_ready), 32'h2);
        req_valid = 2'b11;
        #1;
        check_eq("t5_ptr_zero", 32'(req_ready), 32'h1);
        req_valid = 2'b10;
        @(negedge clk); check_eq("t5_no_resp", 32'(resp_valid), 32'h0);
        tick();
        rst_n = 1'b1;
        @(negedge clk); check_eq("t5_after", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b00;
        repeat (4) tick();
        check_eq("sb_drained", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 8-bit ALU (registered result, sticky OVF flag, registered NZ-of-in_a flag) between NUM_REQ requesters.
- Round-robin arbitration issues at most one operation per cycle, fully pipelined.
- A requester may lock the ALU to run atomic multi-op sequences, such as an add followed by a carry test, without another requester disturbing the shared OVF flag.
- Sits between the CPU datapath or DMA requesters and the ALU instance.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- W, 8, data width; fixed to the ALU width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  request present, per requester.
- req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero).
- req_lock  in  NUM_REQ  keep ownership after this request is accepted.
- req_op  in  3*NUM_REQ  ALU op code per requester (slice i = bits 3i+2:3i).
- req_a  in  W*NUM_REQ  operand A per requester.
- req_b  in  W*NUM_REQ  operand B per requester.
- resp_valid  out  NUM_REQ  one-hot; result for requester i is on resp_* this cycle.
- resp_data  out  W  ALU result (alu_out passthrough).
- resp_ovf  out  1  ALU OVF flag (passthrough).
- resp_nz  out  1  ALU NZ flag (passthrough).
- alu_op  out  3  to ALU op.
- alu_a  out  W  to ALU in_a.
- alu_b  out  W  to ALU in_b.
- alu_out  in  W  from ALU.
- alu_ovf  in  1  from ALU OVF_out.
- alu_nz  in  1  from ALU NZ_out.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - alu_op=000 (pass A), alu_a=0, alu_b=0.
  - resp_valid=0, rr pointer=0, state=OPEN, owner=0, all internal valid bits 0.
  - The ALU itself has no reset; resp_valid=0 masks its undefined outputs.
- Handshake: a transfer for requester i occurs on an edge where req_valid[i] & req_ready[i].
  - req_ready is combinational from req_valid, state and the rr pointer.
  - At most one bit of req_ready is set per cycle.
  - The requester holds op/a/b/lock stable while valid and not ready.
- Arbitration in state OPEN:
  - Grant the first requester with req_valid set, searching from the rr pointer upward with wrap.
  - On a transfer, rr pointer <= granted index + 1 (mod NUM_REQ).
- Arbitration in state LOCKED(owner):
  - Only the owner can be granted; other requesters see req_ready=0.
  - The rr pointer is frozen.
- State transitions:
  - OPEN -> LOCKED(i): transfer from i with req_lock[i]=1.
  - LOCKED(i) -> LOCKED(i): transfer with req_lock=1.
  - LOCKED(i) -> OPEN: transfer with req_lock=0; the final op of the sequence still executes.
  - LOCKED(i) -> LOCKED(i) with no transfer: the owner stalls indefinitely. There is no timeout.
- Pipeline, with a transfer on edge E0:
  - E0: alu_op/alu_a/alu_b <= granted fields; stage1 valid and index are registered.
  - E1: the ALU registers the result and flags; stage2 valid and index <= stage1.
  - Cycle after E1: resp_valid[index]=1 and resp_data/resp_ovf/resp_nz = ALU outputs.
  - Latency: 2 edges from transfer to response.
  - Throughput: 1 op/cycle, back-to-back across requesters.
- alu_op/a/b hold their last value when no transfer occurs. The ALU keeps computing, but no response is flagged.
- Flag semantics:
  - resp_nz reflects operand A of the same op.
  - resp_ovf is the shared sticky flag: it is updated only by op 001 and otherwise shows the last op-001 carry from any requester.
  - Atomic carry use requires the lock.
- Responses have no backpressure; the requester must sample in its resp_valid cycle.
- Boundaries:
  - All requesters valid in OPEN: strict rotation, each granted once per NUM_REQ cycles.
  - Owner drops req_valid while LOCKED: the lock is kept.
  - req_lock with no transfer: ignored.
  - Reset asserted mid-operation: in-flight ops are discarded with no resp_valid, and the lock is released.

Decomposition:
- Shared package alu_pkg holds:
  - op code constants ALU_PASS_A=000, ALU_ADD_OVF=001, ALU_AND=010, ALU_XOR=011, ALU_PASS_B=100, ALU_ADD=101;
  - state encoding OPEN/LOCKED;
  - width W.
- One sub-module: rr_grant (round-robin priority picker with pointer and mask inputs, combinational one-hot output).
- Lock FSM and pipeline registers stay in alu_arbiter.

Test Plan:
- Single op: req0 op=001, a=0xF0, b=0x20.
  - Required: req_ready[0]=1 in the transfer cycle.
  - Required: resp_valid=01 exactly 2 edges later, with resp_data=0x10, resp_ovf=1, resp_nz=1.
- Contention: req0 and req1 both valid with ops 101 (a=1,b=2) and 010 (a=0xFF,b=0x0F).
  - Required: grants alternate 0,1,0,1.
  - Required: responses 0x03 (to req0) and 0x0F (to req1) on consecutive cycles.
- Lock: req0 sends op=001 a=0xFF b=0x01 with lock=1, then op=000 a=0x00 with lock=0, while req1 is valid throughout.
  - Required: req1 is not granted until the second req0 transfer completes.
  - Required: req0 responses are 0x00/ovf=1, then 0x00/ovf=1 (sticky), nz=0.
- Owner idle while locked: req0 locks and then deasserts valid for 5 cycles.
  - Required: req1 stays ungranted for all 5 cycles.
  - Required: req1 is granted in the cycle after req0's unlocking transfer.
- Reset mid-flight: assert rst_n=0 one cycle after a transfer, while LOCKED.
  - Required: no resp_valid, alu_op=000, state OPEN, rr pointer=0.
  - Required: req1 is granted immediately after release.
